// File: rtl/audio_i2s_tx.sv
// I2S serialiser: one 16-bit stereo pair per 2^(LRCK_BIT+1) clk frame, left MSB out 16 clk after capture, no backpressure.
// Optional SPEAKER_MUTE_EN adds a mute input that zeroes the pair captured at the frame wrap.
module audio_i2s_tx #(
    parameter int MCLK_BIT = 1,
    parameter int SCK_BIT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] audio_in_left,
    input  logic [15:0] audio_in_right,
`ifdef SPEAKER_MUTE_EN
    input  logic        mute,
`endif
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    localparam int LRCK_BIT = SCK_BIT + 5;
    localparam int CW       = LRCK_BIT + 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [15:0]   hold_l;
    logic [15:0]   hold_r;
    logic          prev_r0;
    logic          wrap;
    logic [4:0]    slot_next;
    logic [3:0]    bit_idx;
    logic [15:0]   cap_l;
    logic [15:0]   cap_r;
    logic          sdin_next;

    assign cnt_next  = cnt + 1'b1;
    assign wrap      = &cnt;
    assign slot_next = cnt_next[LRCK_BIT:SCK_BIT+1];
    // Slots 1..16 map to hold_l[15..0] and 17..31 to hold_r[15..1]; both are -slot mod 16.
    assign bit_idx   = 4'd0 - slot_next[3:0];

`ifdef SPEAKER_MUTE_EN
    assign cap_l = mute ? 16'h0000 : audio_in_left;
    assign cap_r = mute ? 16'h0000 : audio_in_right;
`else
    assign cap_l = audio_in_left;
    assign cap_r = audio_in_right;
`endif

    // At the wrap edge prev_r0 is being loaded in the same cycle, so slot 0 takes hold_r[0] directly.
    always_comb begin
        sdin_next = 1'b0;
        if (slot_next == 5'd0)
            sdin_next = wrap ? hold_r[0] : prev_r0;
        else if (slot_next <= 5'd16)
            sdin_next = hold_l[bit_idx];
        else
            sdin_next = hold_r[bit_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            hold_l     <= '0;
            hold_r     <= '0;
            prev_r0    <= 1'b0;
            audio_sdin <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            audio_sdin <= sdin_next;
            if (wrap) begin
                hold_l  <= cap_l;
                hold_r  <= cap_r;
                prev_r0 <= hold_r[0];
            end
        end
    end

    assign audio_mclk = cnt[MCLK_BIT];
    assign audio_sck  = cnt[SCK_BIT];
    assign audio_lrck = cnt[LRCK_BIT];

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: clock periods, frame deserialisation, mid-frame changes, reset and mute.
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] audio_in_left = 16'h0000;
    logic [15:0] audio_in_right = 16'h0000;
`ifdef SPEAKER_MUTE_EN
    logic        mute = 1'b0;
`endif
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;

    int errors = 0;
    int checks = 0;

    // Reference frame position: counts clk edges since reset release.
    logic [8:0] tb_cnt;

    audio_i2s_tx dut (
        .clk            (clk),
        .rst            (rst),
        .audio_in_left  (audio_in_left),
        .audio_in_right (audio_in_right),
`ifdef SPEAKER_MUTE_EN
        .mute           (mute),
`endif
        .audio_mclk     (audio_mclk),
        .audio_lrck     (audio_lrck),
        .audio_sck      (audio_sck),
        .audio_sdin     (audio_sdin)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 9'd0;
        else     tb_cnt <= tb_cnt + 9'd1;
    end

    typedef struct {
        logic [15:0] l_in;
        logic [15:0] r_in;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cnt(input int target);
        int guard = 0;
        while (int'(tb_cnt) != target && guard < 1100) begin
            @(negedge clk);
            guard++;
        end
        if (int'(tb_cnt) != target) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt: got %0d expected %0d", tb_cnt, target);
        end
    endtask

    // Deserialises the frame starting at the next cnt==0, sampling mid-slot at the sck rising edge.
    task automatic get_frame(output logic [15:0] l, output logic [15:0] r, output logic s0);
        int s;
        l  = 16'h0000;
        r  = 16'h0000;
        s0 = 1'b0;
        wait_cnt(0);
        for (int k = 0; k < 528; k++) begin
            if (k > 0) @(negedge clk);
            if (k % 16 == 8) begin
                s = k / 16;
                if (s == 0)        s0 = audio_sdin;
                else if (s <= 16)  l[16 - s] = audio_sdin;
                else if (s <= 31)  r[32 - s] = audio_sdin;
                else               r[0] = audio_sdin;
            end
        end
    endtask

    initial begin
        logic [15:0] fl;
        logic [15:0] fr;
        logic        f0;
        int rm[2];
        int rs[2];
        int rl[2];
        int nm;
        int ns;
        int nl;
        int lrck_first;
        logic pm;
        logic ps;
        logic pl;

        vecs[0] = '{16'hA5C3, 16'h3C5A, 16'hA5C3, 16'h3C5A};
        vecs[1] = '{16'h0240, 16'hFDC0, 16'h0240, 16'hFDC0};
        vecs[2] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        vecs[3] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
        vecs[4] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};

        // Reset state and clock periods
        #2 rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5 || i == 19)
                check("reset_outputs", {28'h0, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'h0);
        end
        rst = 1'b0;
        rm = '{0, 0}; rs = '{0, 0}; rl = '{0, 0};
        nm = 0; ns = 0; nl = 0; lrck_first = -1;
        pm = 1'b0; ps = 1'b0; pl = 1'b0;
        for (int n = 0; n < 1100; n++) begin
            if (n > 0) @(negedge clk);
            if (audio_mclk && !pm && nm < 2) begin rm[nm] = n; nm++; end
            if (audio_sck  && !ps && ns < 2) begin rs[ns] = n; ns++; end
            if (audio_lrck && !pl && nl < 2) begin
                if (nl == 0) lrck_first = int'(tb_cnt);
                rl[nl] = n;
                nl++;
            end
            pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
        end
        check("mclk_period", 32'(rm[1] - rm[0]), 32'd4);
        check("sck_period",  32'(rs[1] - rs[0]), 32'd16);
        check("lrck_period", 32'(rl[1] - rl[0]), 32'd512);
        check("lrck_rise_cnt", 32'(lrck_first), 32'd256);

        // Table of constant pairs, one frame each
        for (int v = 0; v < 5; v++) begin
            audio_in_left  = vecs[v].l_in;
            audio_in_right = vecs[v].r_in;
            get_frame(fl, fr, f0);
            check($sformatf("vec%0d_left", v),  {16'h0, fl}, {16'h0, vecs[v].exp_l});
            check($sformatf("vec%0d_right", v), {16'h0, fr}, {16'h0, vecs[v].exp_r});
        end

        // Input change mid-frame must not disturb the frame in flight
        audio_in_left  = 16'h0080;
        audio_in_right = 16'h0000;
        wait_cnt(0);
        fork
            get_frame(fl, fr, f0);
            begin
                wait_cnt(100);
                audio_in_left = 16'hFF80;
            end
        join
        check("midchange_cur_left", {16'h0, fl}, 32'h0080);
        check("midchange_cur_right", {16'h0, fr}, 32'h0000);
        get_frame(fl, fr, f0);
        check("midchange_next_left", {16'h0, fl}, 32'hFF80);

        // Reset in the middle of a frame
        audio_in_left  = 16'hFFFF;
        audio_in_right = 16'h0000;
        wait_cnt(0);
        wait_cnt(300);
        check("pre_reset_clocks", {29'h0, audio_mclk, audio_sck, audio_lrck}, 32'h3);
        rst = 1'b1;
        #1;
        check("midreset_immediate", {28'h0, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'h0);
        repeat (4) @(negedge clk);
        check("midreset_held", {28'h0, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'h0);
        rst = 1'b0;
        get_frame(fl, fr, f0);
        check("post_reset_frame0", {fl, fr}, 32'h0000_0000);
        get_frame(fl, fr, f0);
        check("post_reset_frame1", {fl, fr}, 32'hFFFF_0000);

`ifdef SPEAKER_MUTE_EN
        audio_in_left  = 16'h7FFF;
        audio_in_right = 16'h7FFF;
        get_frame(fl, fr, f0);
        check("premute_frame", {fl, fr}, 32'h7FFF_7FFF);
        mute = 1'b1;
        fork
            get_frame(fl, fr, f0);
            begin
                wait_cnt(0);
                wait_cnt(100);
                mute = 1'b0;
            end
        join
        check("muted_frame", {fl, fr}, 32'h0000_0000);
        check("muted_slot0", {31'h0, f0}, 32'h1);
        get_frame(fl, fr, f0);
        check("unmuted_frame", {fl, fr}, 32'h7FFF_7FFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Serialiser for the 16-bit stereo samples produced by the note generator. Each frame it captures one signed left/right pair and drives it to the Pmod I2S2 DAC as standard I2S: master clock, bit clock, word select and serial data. It sits between the note generator and the board audio pins, and all of its outputs are derived from one free-running counter on the crystal clock.

## Interface
- MCLK_BIT, 1: counter bit driven as audio_mclk; gives clk/4.
- SCK_BIT, 3: counter bit driven as audio_sck; gives clk/16. Must be greater than MCLK_BIT. LRCK_BIT is fixed at SCK_BIT+5.
- clk  input  1  crystal clock, 100 MHz.
- rst  input  1  reset; asynchronous, active-high.
- audio_in_left  input  16  left sample, two's complement.
- audio_in_right  input  16  right sample, two's complement.
- mute  input  1  forces silence. Present only with SPEAKER_MUTE_EN.
- audio_mclk  output  1  DAC master clock.
- audio_lrck  output  1  word select: 0 = left, 1 = right.
- audio_sck  output  1  bit clock.
- audio_sdin  output  1  serial data, MSB first.

## Operation
- **Counter:** cnt is LRCK_BIT+1 bits wide (9 at defaults), free-running, and wraps from all-ones to 0. One frame is 2^(LRCK_BIT+1) clk cycles, i.e. 512 clk at defaults, giving 195.3 kHz.
- **Clock outputs:** audio_mclk = cnt[MCLK_BIT], audio_sck = cnt[SCK_BIT], audio_lrck = cnt[LRCK_BIT]. All three come straight from flop bits, with no combinational logic, so they are glitch-free.
- **Slot index:** s = cnt[LRCK_BIT:SCK_BIT+1], range 0..31, one bit per sck period.
- **Sample capture:** at the clk edge where cnt wraps from all-ones to 0:
  - hold_l and hold_r load audio_in_left and audio_in_right.
  - In the same edge, prev_r0 loads the old hold_r[0].
  - Inputs are ignored at every other edge.
  - Values pass through unchanged, with no scaling or saturation.
- **Slot mapping (I2S one-bit delay):**
  - s=0 carries prev_r0.
  - s=1..15 carry hold_l[15..1].
  - s=16 carries hold_l[0].
  - s=17..31 carry hold_r[15..1].
  - hold_r[0] goes out in s=0 of the next frame.
- **audio_sdin:** a flop, loaded from the slot of cnt_next. In every cycle where cnt = c, audio_sdin equals the bit for slot(c).
  - Data therefore changes on the clk edge where audio_sck falls.
  - Data is stable for 2^SCK_BIT clk on either side of the sck rising edge, which is where the DAC samples.
- **Reset values:** cnt, hold_l, hold_r, prev_r0 and audio_sdin are all 0, so every output is 0 during reset.

## Timing
- audio_mclk toggles every 2^MCLK_BIT clk (every 2 at defaults).
- audio_sck toggles every 2^SCK_BIT clk (every 8).
- audio_lrck toggles every 2^LRCK_BIT clk (every 256).
- **Latency:** a sample pair captured at the wrap edge has its left MSB on audio_sdin from cnt = 2^(SCK_BIT+1), i.e. 16 clk after capture. Its last bit, right LSB, leaves in slot 0 of the following frame.
- **After reset release:**
  - cnt starts at 0.
  - Frame 0 transmits all zeros, because the hold registers are still 0.
  - The inputs present in the last cycle of frame 0 are the first pair to appear, in frame 1.
- **Reset mid-frame:**
  - All state clears immediately, without waiting for a clk edge.
  - The partial frame is abandoned; no resynchronisation or flush.
- **Input timing:** inputs need to be stable only in the clk cycle ending at the wrap edge. Changes mid-frame do not affect the frame in flight.

## Configuration
- **SPEAKER_MUTE_EN defined:**
  - The mute port exists.
  - If mute=1 at the wrap edge, hold_l and hold_r load 0 instead of the inputs.
  - prev_r0 still loads the old hold_r[0], so the frame in progress finishes cleanly.
- **SPEAKER_MUTE_EN undefined:** the mute port and its logic are absent, and the inputs are always captured.

## Test plan
1. **Reset:** hold rst=1 for 20 clk, then release. During reset all outputs are 0. After release:
   - audio_mclk period is 4 clk.
   - audio_sck period is 16 clk.
   - audio_lrck period is 512 clk, going high at cnt=256.
2. **Constant stimulus:** hold L=16'hA5C3, R=16'h3C5A. Deserialise audio_sdin at sck rising edges, from frame 1 onward:
   - slots 1..16 give 16'hA5C3;
   - slots 17..31 plus slot 0 of the next frame give 16'h3C5A.
3. **Mid-frame input change:** switch L from 16'h0080 to 16'hFF80 at cnt=100. The current frame still shifts 16'h0080; the next frame shifts 16'hFF80.
4. **Note-generator levels:** L=16'h0240, R=-16'h0240 (16'hFDC0). Both deserialise bit-exact, with sign preserved.
5. **Reset mid-frame:** assert rst at cnt=300 with L=16'hFFFF.
   - All outputs go to 0 immediately.
   - After release, the frame restarts at cnt=0 and outputs zeros.
   - 16'hFFFF appears from frame 1.
6. **Mute (SPEAKER_MUTE_EN defined):** L=R=16'h7FFF, with mute=1 at one wrap edge.
   - That frame is all zeros except slot 0, which is 1 (the previous R[0]).
   - When mute returns to 0, 16'h7FFF reappears in the next frame.
